data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-port request scheduler in front of the single-port word-addressed `data_memory`. It arbitrates between the core load/store port (port 0) and the debug/program-loader port (port 1). Each accepted request is sequenced into memory read, capture and write cycles, with read-modify-write for byte-enabled stores. It also returns a one-cycle response to the requester.

## Interface
- `DATA_WIDTH`, 32 (from `pkg_config`): data word width.
- `MEM_SIZE`, 1024: memory depth in words.
- `ADDR_WIDTH`, `$clog2(MEM_SIZE)`: memory word-address width.
- `clk_i` input 1: single clock; all state updates on rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `req_valid_i` input [1:0]: request valid, one bit per port.
- `req_ready_o` output [1:0]: request accepted; the handshake completes on valid & ready.
- `req_we_i` input [1:0]: 1 = store, 0 = load.
- `req_be_i` input [1:0][DATA_WIDTH/8-1:0]: store byte enables.
- `req_addr_i` input [1:0][31:0]: byte address.
- `req_wdata_i` input [1:0][DATA_WIDTH-1:0]: store data, byte lanes aligned to the word.
- `rsp_valid_o` output [1:0]: one-cycle response pulse to the granted port.
- `rsp_rdata_o` output DATA_WIDTH: load data, shared by both ports; qualify with `rsp_valid_o`.
- `mem_we_o` output 1: to `data_memory.we_i`.
- `mem_addr_o` output ADDR_WIDTH: to `data_memory.addr_i`.
- `mem_wdata_o` output DATA_WIDTH: to `data_memory.data_i`.
- `mem_rdata_i` input DATA_WIDTH: from `data_memory.data_o`.

## Operation
- States: IDLE, READ, CAPT, WRITE, RESP.
- **IDLE**
  - When any `req_valid_i` is set, grant one port and assert `req_ready_o` for that port only, combinationally, in this cycle.
  - Latch that port's we, be, address and wdata, and record it as the grant owner.
  - Next state:
    - Load, or store with be ∉ {0, all-ones): READ.
    - Store with be = all-ones: WRITE.
    - Store with be = 0: RESP. This is a no-op; the memory is never written.
- **READ**: drive `mem_addr_o` = latched word address, `mem_we_o` = 0. Next state CAPT.
- **CAPT**
  - Keep driving the same address.
  - Register `mem_rdata_i` into the read buffer. Sampling one cycle after the address is first driven tolerates both combinational and registered memory reads.
  - Next state: RESP for a load; WRITE for a partial store.
- **WRITE**
  - Drive `mem_we_o` = 1 for exactly one cycle.
  - `mem_wdata_o` is built per byte: lane i = `req_wdata` lane i if be[i], otherwise the read-buffer lane i.
  - Next state RESP.
- **RESP**
  - Assert `rsp_valid_o` for the owner port for one cycle.
  - `rsp_rdata_o` = read buffer for loads, 0 for stores.
  - Next state IDLE. No request is accepted in this cycle.
- Word address = `req_addr_i[ADDR_WIDTH+1:2]`.
  - `addr[1:0]` is ignored.
  - Bits above ADDR_WIDTH+1 are ignored, so addresses wrap modulo MEM_SIZE words.
- Loads ignore `req_be_i` and always return the full word. Byte/halfword extraction and sign-extension belong to the core LSU.
- Arbitration with both ports valid in IDLE: the port not granted most recently wins. The last-grant pointer resets so that port 0 wins first. A single valid port always wins.
- Requesters hold valid and payload stable until ready. Deasserting valid before ready is legal and drops the request.
- Outside the WRITE state: `mem_we_o` = 0. Outside READ, CAPT and WRITE: `mem_addr_o` = 0 and `mem_wdata_o` = 0.

## Timing
- Accept cycle T (ready high). Response timing:
  - Load: `rsp_valid_o` at T+3.
  - Partial store: memory write at T+3, `rsp_valid_o` at T+4.
  - Full store: memory write at T+1, `rsp_valid_o` at T+2.
  - be = 0 store: `rsp_valid_o` at T+1.
- One request in flight at a time. The next accept is possible at the cycle after RESP.
- Reset values (also in the cycle after any `rst_i`):
  - State IDLE, last-grant pointer = port 1.
  - Read buffer 0.
  - All outputs 0, except `req_ready_o`, which follows the IDLE grant logic.
- Reset mid-operation aborts the transaction:
  - No `mem_we_o` and no response after the reset edge.
  - The requester must reissue.
  - A memory write already performed stays in memory.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin arbitration as described above.
- Not defined: fixed priority, port 0 always wins over port 1. The last-grant pointer is not implemented.

## Test plan
- Memory word 2 = 32'h1122_3344; port 0 loads 32'h0000_0008 → `rsp_valid_o` = 2'b01 exactly 3 cycles after accept, `rsp_rdata_o` = 32'h1122_3344, `mem_we_o` never high.
- Partial store, be = 4'b0101, wdata 32'hAABB_CCDD to word 2 → a single `mem_we_o` pulse with `mem_wdata_o` = 32'h11BB_33DD; a following load returns 32'h11BB_33DD.
- Full store, be = 4'hF, 32'hDEAD_BEEF to byte address 32'h0000_1000 (wraps to word 0 with MEM_SIZE = 1024) → write at T+1 to `mem_addr_o` = 0, response at T+2.
- Both ports hold valid for 4 transactions → grants alternate 0, 1, 0, 1 with `DMEM_ARB_RR_EN`; without it, all go to port 0 while port 0 stays valid.
- Store with be = 0 → response at T+1, `mem_we_o` stays 0, memory unchanged.
- `rst_i` asserted in the CAPT state of a partial store → no write, no response, all outputs 0 the next cycle; a reissued request completes normally.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - request/response and data_memory port bundle of the data memory arbiter
interface data_mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic [1:0]                 req_valid_i;
    logic [1:0]                 req_ready_o;
    logic [1:0]                 req_we_i;
    logic [1:0][BE_WIDTH-1:0]   req_be_i;
    logic [1:0][31:0]           req_addr_i;
    logic [1:0][DATA_WIDTH-1:0] req_wdata_i;
    logic [1:0]                 rsp_valid_o;
    logic [DATA_WIDTH-1:0]      rsp_rdata_o;
    logic                       mem_we_o;
    logic [ADDR_WIDTH-1:0]      mem_addr_o;
    logic [DATA_WIDTH-1:0]      mem_wdata_o;
    logic [DATA_WIDTH-1:0]      mem_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_be_i, req_addr_i, req_wdata_i, mem_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output req_valid_i, req_we_i, req_be_i, req_addr_i, req_wdata_i, mem_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port scheduler for data_memory with read-modify-write byte stores
// DMEM_ARB_RR_EN selects round-robin arbitration; otherwise port 0 has fixed priority.
module data_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 1024,
    parameter int ADDR_WIDTH = $clog2(MEM_SIZE)
) (
    input logic               clk_i,
    input logic               rst_i,
    data_mem_arbiter_if.slave bus
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, READ, CAPT, WRITE, RESP} state_t;

    state_t                state;
    logic                  lat_we;
    logic                  owner;
    logic [BE_WIDTH-1:0]   lat_be;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [DATA_WIDTH-1:0] rbuf;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [1:0]            rsp_valid;

    logic                  gsel;
    logic                  accept;
    logic                  sel_we;
    logic [BE_WIDTH-1:0]   sel_be;
    logic [31:0]           sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [ADDR_WIDTH-1:0] sel_word;
    logic                  unused_addr_bits;

`ifdef DMEM_ARB_RR_EN
    logic last_grant;

    always_comb begin
        if (bus.req_valid_i == 2'b11) gsel = ~last_grant;
        else                          gsel = ~bus.req_valid_i[0];
    end
`else
    assign gsel = ~bus.req_valid_i[0];
`endif

    // Ready is withheld during reset so a handshake is never lost to the reset edge.
    assign accept          = (state == IDLE) && !rst_i && (|bus.req_valid_i);
    assign bus.req_ready_o = accept ? (gsel ? 2'b10 : 2'b01) : 2'b00;

    assign sel_we           = bus.req_we_i[gsel];
    assign sel_be           = bus.req_be_i[gsel];
    assign sel_addr         = bus.req_addr_i[gsel];
    assign sel_wdata        = bus.req_wdata_i[gsel];
    assign sel_word         = sel_addr[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{sel_addr[31:ADDR_WIDTH+2], sel_addr[1:0]};

    function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] wd,
                                                    input logic [DATA_WIDTH-1:0] rd,
                                                    input logic [BE_WIDTH-1:0]   be);
        for (int i = 0; i < BE_WIDTH; i++)
            merge[8*i +: 8] = be[i] ? wd[8*i +: 8] : rd[8*i +: 8];
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            lat_we    <= 1'b0;
            lat_be    <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            owner     <= 1'b0;
            rbuf      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= '0;
`ifdef DMEM_ARB_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= '0;
            case (state)
                IDLE: if (accept) begin
                    lat_we    <= sel_we;
                    lat_be    <= sel_be;
                    lat_addr  <= sel_word;
                    lat_wdata <= sel_wdata;
                    owner     <= gsel;
`ifdef DMEM_ARB_RR_EN
                    last_grant <= gsel;
`endif
                    if (!sel_we || (sel_be != '0 && sel_be != '1)) begin
                        state    <= READ;
                        mem_addr <= sel_word;
                    end else if (sel_be == '1) begin
                        state     <= WRITE;
                        mem_we    <= 1'b1;
                        mem_addr  <= sel_word;
                        mem_wdata <= sel_wdata;
                    end else begin
                        state     <= RESP;
                        rsp_valid <= {gsel, ~gsel};
                    end
                end
                READ: begin
                    state    <= CAPT;
                    mem_addr <= lat_addr;
                end
                // Sampling here, a cycle after the address first appears, suits both read styles.
                CAPT: begin
                    rbuf <= bus.mem_rdata_i;
                    if (lat_we) begin
                        state     <= WRITE;
                        mem_we    <= 1'b1;
                        mem_addr  <= lat_addr;
                        mem_wdata <= merge(lat_wdata, bus.mem_rdata_i, lat_be);
                    end else begin
                        state     <= RESP;
                        rsp_valid <= {owner, ~owner};
                    end
                end
                WRITE: begin
                    state     <= RESP;
                    rsp_valid <= {owner, ~owner};
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_we_o    = mem_we;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_wdata_o = mem_wdata;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_rdata_o = (state == RESP && !lat_we) ? rbuf : '0;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - self-checking bench for data_mem_arbiter against a transaction-level memory model
module tb_data_mem_arbiter;
    localparam int DW = 32;
    localparam int MS = 1024;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    data_mem_arbiter #(.DATA_WIDTH(DW), .MEM_SIZE(MS)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    logic [DW-1:0] dmem    [MS];
    logic [DW-1:0] ref_mem [MS];

    assign bus.mem_rdata_i = dmem[bus.mem_addr_o];
    always @(posedge clk) if (bus.mem_we_o) dmem[bus.mem_addr_o] = bus.mem_wdata_o;

    int n_cmp = 0;
    int n_fail = 0;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int            wr_cnt = 0, wr_cyc = 0, rsp_cnt = 0, rsp_cyc = 0, acc_cnt = 0;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data, rsp_data;
    logic [1:0]    rsp_port, acc_port;

    always @(negedge clk) begin
        if (bus.mem_we_o) begin
            wr_cnt++; wr_cyc = cyc; wr_addr = bus.mem_addr_o; wr_data = bus.mem_wdata_o;
        end
        if (|bus.rsp_valid_o) begin
            rsp_cnt++; rsp_cyc = cyc; rsp_port = bus.rsp_valid_o; rsp_data = bus.rsp_rdata_o;
        end
        if (|(bus.req_valid_i & bus.req_ready_o)) begin
            acc_cnt++; acc_port = bus.req_ready_o;
        end
    end

    int b_wr, b_rsp, t_acc;
    bit timed_out;

    function automatic logic [31:0] merged(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    function automatic int exp_rsp_lat(input logic we, input logic [3:0] be);
        if (!we) return 3;
        if (be == 4'h0) return 1;
        if (be == 4'hF) return 2;
        return 4;
    endfunction

    task automatic issue(input int p, input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
        bus.req_we_i[p] = we; bus.req_be_i[p] = be; bus.req_addr_i[p] = addr; bus.req_wdata_i[p] = wd;
        bus.req_valid_i[p] = 1'b1;
    endtask

    task automatic do_reset;
        @(posedge clk); #1 rst = 1'b1; bus.req_valid_i = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_txn(input int p, input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
        int k;
        b_wr = wr_cnt; b_rsp = rsp_cnt; timed_out = 0;
        @(posedge clk); #1 issue(p, we, be, addr, wd);
        for (k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (bus.req_ready_o[p]) break;
        end
        if (k == 20) timed_out = 1;
        t_acc = cyc;
        @(posedge clk); #1 bus.req_valid_i[p] = 1'b0;
        for (k = 0; k < 12; k++) begin
            if (rsp_cnt != b_rsp) break;
            @(negedge clk); #1;
        end
        if (rsp_cnt == b_rsp) timed_out = 1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.req_valid_i = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.mem_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %b want 0", bus.mem_we_o); end
        n_cmp++; if (bus.mem_addr_o !== '0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr_o); end
        n_cmp++; if (bus.mem_wdata_o !== '0) begin n_fail++; $display("FAIL reset_mem_wdata got %h want 0", bus.mem_wdata_o); end
        n_cmp++; if (bus.rsp_valid_o !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 00", bus.rsp_valid_o); end
        n_cmp++; if (bus.rsp_rdata_o !== '0) begin n_fail++; $display("FAIL reset_rsp_rdata got %h want 0", bus.rsp_rdata_o); end
        n_cmp++; if (bus.req_ready_o !== 2'b00) begin n_fail++; $display("FAIL reset_ready_idle got %b want 00", bus.req_ready_o); end
        #1 issue(0, 1'b0, 4'h0, 32'h4, 32'h0); issue(1, 1'b0, 4'h0, 32'h8, 32'h0);
        #1;
        n_cmp++; if (bus.req_ready_o !== 2'b01) begin n_fail++; $display("FAIL reset_first_grant got %b want 01", bus.req_ready_o); end
        bus.req_valid_i = 2'b10;
        #1;
        n_cmp++; if (bus.req_ready_o !== 2'b10) begin n_fail++; $display("FAIL single_valid_p1 got %b want 10", bus.req_ready_o); end
        bus.req_valid_i = 2'b00;
    endtask

    task automatic test_load;
        run_txn(0, 1'b0, 4'h3, 32'h0000_0008, 32'hFFFF_FFFF);
        n_cmp++; if (timed_out) begin n_fail++; $display("FAIL load_timeout got timeout want response"); end
        n_cmp++; if (rsp_cyc - t_acc !== 3) begin n_fail++; $display("FAIL load_lat got %0d want 3", rsp_cyc - t_acc); end
        n_cmp++; if (rsp_port !== 2'b01) begin n_fail++; $display("FAIL load_port got %b want 01", rsp_port); end
        n_cmp++; if (rsp_data !== 32'h1122_3344) begin n_fail++; $display("FAIL load_data got %h want 11223344", rsp_data); end
        n_cmp++; if (wr_cnt - b_wr !== 0) begin n_fail++; $display("FAIL load_no_write got %0d writes want 0", wr_cnt - b_wr); end
    endtask

    task automatic test_partial_store;
        run_txn(0, 1'b1, 4'b0101, 32'h0000_0008, 32'hAABB_CCDD);
        ref_mem[2] = merged(ref_mem[2], 32'hAABB_CCDD, 4'b0101);
        n_cmp++; if (wr_cnt - b_wr !== 1) begin n_fail++; $display("FAIL pstore_wr_count got %0d want 1", wr_cnt - b_wr); end
        n_cmp++; if (wr_data !== 32'h11BB_33DD) begin n_fail++; $display("FAIL pstore_wdata got %h want 11bb33dd", wr_data); end
        n_cmp++; if (wr_addr !== 10'd2) begin n_fail++; $display("FAIL pstore_addr got %0d want 2", wr_addr); end
        n_cmp++; if (wr_cyc - t_acc !== 3) begin n_fail++; $display("FAIL pstore_wr_lat got %0d want 3", wr_cyc - t_acc); end
        n_cmp++; if (rsp_cyc - t_acc !== 4) begin n_fail++; $display("FAIL pstore_rsp_lat got %0d want 4", rsp_cyc - t_acc); end
        n_cmp++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL pstore_rsp_data got %h want 0", rsp_data); end
        run_txn(1, 1'b0, 4'h0, 32'h0000_000A, 32'h0);
        n_cmp++; if (rsp_data !== 32'h11BB_33DD) begin n_fail++; $display("FAIL pstore_readback got %h want 11bb33dd", rsp_data); end
        n_cmp++; if (rsp_port !== 2'b10) begin n_fail++; $display("FAIL pstore_readback_port got %b want 10", rsp_port); end
    endtask

    task automatic test_full_store_wrap;
        run_txn(0, 1'b1, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF);
        ref_mem[0] = 32'hDEAD_BEEF;
        n_cmp++; if (wr_cnt - b_wr !== 1) begin n_fail++; $display("FAIL fstore_wr_count got %0d want 1", wr_cnt - b_wr); end
        n_cmp++; if (wr_addr !== 10'd0) begin n_fail++; $display("FAIL fstore_wrap_addr got %0d want 0", wr_addr); end
        n_cmp++; if (wr_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL fstore_wdata got %h want deadbeef", wr_data); end
        n_cmp++; if (wr_cyc - t_acc !== 1) begin n_fail++; $display("FAIL fstore_wr_lat got %0d want 1", wr_cyc - t_acc); end
        n_cmp++; if (rsp_cyc - t_acc !== 2) begin n_fail++; $display("FAIL fstore_rsp_lat got %0d want 2", rsp_cyc - t_acc); end
    endtask

    task automatic test_be_zero;
        run_txn(1, 1'b1, 4'h0, 32'h0000_001C, 32'h5A5A_A5A5);
        n_cmp++; if (rsp_cyc - t_acc !== 1) begin n_fail++; $display("FAIL be0_rsp_lat got %0d want 1", rsp_cyc - t_acc); end
        n_cmp++; if (rsp_port !== 2'b10) begin n_fail++; $display("FAIL be0_port got %b want 10", rsp_port); end
        n_cmp++; if (wr_cnt - b_wr !== 0) begin n_fail++; $display("FAIL be0_no_write got %0d writes want 0", wr_cnt - b_wr); end
        n_cmp++; if (dmem[7] !== ref_mem[7]) begin n_fail++; $display("FAIL be0_mem got %h want %h", dmem[7], ref_mem[7]); end
    endtask

    task automatic test_reset_mid;
        int k;
        b_wr = wr_cnt; b_rsp = rsp_cnt;
        @(posedge clk); #1 issue(0, 1'b1, 4'b0011, 32'h0000_0014, 32'h1234_5678);
        for (k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (bus.req_ready_o[0]) break;
        end
        n_cmp++; if (k == 20) begin n_fail++; $display("FAIL midrst_accept got timeout want accept"); end
        @(posedge clk); #1 bus.req_valid_i[0] = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.mem_we_o !== 1'b0) begin n_fail++; $display("FAIL midrst_mem_we got %b want 0", bus.mem_we_o); end
        n_cmp++; if (bus.mem_addr_o !== '0) begin n_fail++; $display("FAIL midrst_mem_addr got %h want 0", bus.mem_addr_o); end
        n_cmp++; if (bus.mem_wdata_o !== '0) begin n_fail++; $display("FAIL midrst_mem_wdata got %h want 0", bus.mem_wdata_o); end
        n_cmp++; if (bus.rsp_valid_o !== 2'b00) begin n_fail++; $display("FAIL midrst_rsp_valid got %b want 00", bus.rsp_valid_o); end
        repeat (6) @(negedge clk);
        n_cmp++; if (wr_cnt - b_wr !== 0) begin n_fail++; $display("FAIL midrst_no_write got %0d want 0", wr_cnt - b_wr); end
        n_cmp++; if (rsp_cnt - b_rsp !== 0) begin n_fail++; $display("FAIL midrst_no_rsp got %0d want 0", rsp_cnt - b_rsp); end
        n_cmp++; if (dmem[5] !== ref_mem[5]) begin n_fail++; $display("FAIL midrst_mem got %h want %h", dmem[5], ref_mem[5]); end
        run_txn(0, 1'b1, 4'b0011, 32'h0000_0014, 32'h1234_5678);
        ref_mem[5] = merged(ref_mem[5], 32'h1234_5678, 4'b0011);
        n_cmp++; if (timed_out) begin n_fail++; $display("FAIL midrst_reissue got timeout want response"); end
        n_cmp++; if (wr_data !== ref_mem[5]) begin n_fail++; $display("FAIL midrst_reissue_wdata got %h want %h", wr_data, ref_mem[5]); end
    endtask

    task automatic test_arbitration;
        logic [1:0] exp_g;
        int b, k;
        do_reset();
        @(posedge clk); #1 issue(0, 1'b0, 4'h0, 32'h4, 32'h0); issue(1, 1'b0, 4'h0, 32'h8, 32'h0);
        for (int n = 0; n < 4; n++) begin
            b = acc_cnt;
            for (k = 0; k < 10; k++) begin
                @(negedge clk); #1;
                if (acc_cnt != b) break;
            end
`ifdef DMEM_ARB_RR_EN
            exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            n_cmp++;
            if (acc_cnt == b || acc_port !== exp_g) begin
                n_fail++; $display("FAIL arb_grant_%0d got %b want %b", n, acc_port, exp_g);
            end
        end
        @(posedge clk); #1 bus.req_valid_i = 2'b00;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_random;
        int p, word, bad;
        logic we;
        logic [3:0] be;
        logic [31:0] addr, wd, exp_rd, exp_new;
        for (int n = 0; n < 40; n++) begin
            p = $urandom_range(0, 1);
            we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: be = 4'h0;
                1: be = 4'hF;
                default: be = 4'($urandom);
            endcase
            addr = $urandom;
            addr[11:2] = 10'($urandom_range(0, 31));
            word = int'(addr[11:2]);
            wd = $urandom;
            exp_rd = we ? 32'h0 : ref_mem[word];
            exp_new = we ? merged(ref_mem[word], wd, be) : ref_mem[word];
            run_txn(p, we, be, addr, wd);
            n_cmp++; if (timed_out) begin n_fail++; $display("FAIL rnd%0d_timeout got timeout want response", n); end
            n_cmp++; if (rsp_cyc - t_acc !== exp_rsp_lat(we, be)) begin n_fail++; $display("FAIL rnd%0d_lat got %0d want %0d", n, rsp_cyc - t_acc, exp_rsp_lat(we, be)); end
            n_cmp++; if (rsp_port !== ((p == 1) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rnd%0d_port got %b want port %0d", n, rsp_port, p); end
            n_cmp++; if (rsp_data !== exp_rd) begin n_fail++; $display("FAIL rnd%0d_rdata got %h want %h", n, rsp_data, exp_rd); end
            n_cmp++; if (wr_cnt - b_wr !== ((we && be != 4'h0) ? 1 : 0)) begin n_fail++; $display("FAIL rnd%0d_wr_count got %0d", n, wr_cnt - b_wr); end
            if (we && be != 4'h0) begin
                n_cmp++; if (wr_addr !== addr[11:2] || wr_data !== exp_new) begin n_fail++; $display("FAIL rnd%0d_write got %h@%0d want %h@%0d", n, wr_data, wr_addr, exp_new, word); end
            end
            ref_mem[word] = exp_new;
        end
        bad = 0;
        for (int i = 0; i < MS; i++) if (dmem[i] !== ref_mem[i]) bad++;
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL final_memory got %0d differing words want 0", bad); end
    endtask

    initial begin
        bus.req_valid_i = '0; bus.req_we_i = '0; bus.req_be_i = '0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
        for (int i = 0; i < MS; i++) begin
            dmem[i] = $urandom;
            ref_mem[i] = dmem[i];
        end
        dmem[2] = 32'h1122_3344;
        ref_mem[2] = 32'h1122_3344;
        test_reset();
        test_load();
        test_partial_store();
        test_full_store_wrap();
        test_be_zero();
        test_reset_mid();
        test_arbitration();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end
endmodule
